stream_to_sdram_writer: RTL

Frame loader for the SLM pipeline, the write-side counterpart of the SDRAM-to-VGA read path. It accepts an 8-bit pixel byte stream over a valid/ready handshake and packs byte pairs into 16-bit words. It writes the words into SDRAM through the Avalon-style write master, honouring waitrequest. Address layout matches the display read path: {frame_id[5:0], line[9:0], word[8:0]}. The first byte of each pair goes in bits [15:8].

---
 rtl/stream_to_sdram_writer_pkg.sv | 36 +++
 rtl/stream_to_sdram_writer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/stream_to_sdram_writer_pkg.sv
// Shared types and constants for the SDRAM frame writer.
// Address field layout matches the SDRAM-to-VGA read path.
package stream_to_sdram_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PACK_U = 3'd1,
        ST_PACK_L = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int ADDR_W    = 25;
    localparam int FRAME_W   = 6;
    localparam int LINE_W    = 10;
    localparam int WORD_W    = 9;
    localparam int PIX_W     = 8;
    localparam int DATA_W    = 16;

    localparam int FRAME_MSB = 24;
    localparam int LINE_LSB  = 9;
    localparam int WORD_LSB  = 0;
    localparam int FRAME_LSB = LINE_LSB + LINE_W;

    localparam int DEF_LINES          = 1024;
    localparam int DEF_WORDS_PER_LINE = 512;

    function automatic logic [ADDR_W-1:0] mk_addr(
        input logic [FRAME_W-1:0] frame,
        input logic [LINE_W-1:0]  line,
        input logic [WORD_W-1:0]  word
    );
        return {frame, line, word};
    endfunction

endpackage

// File: rtl/stream_to_sdram_writer.sv
// Packs an 8-bit pixel stream into 16-bit words and writes one frame
// into SDRAM through an Avalon-style write master.
module stream_to_sdram_writer
    import stream_to_sdram_writer_pkg::*;
#(
    parameter int LINES          = DEF_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    input  logic                iSTART,
    input  logic [FRAME_W-1:0]  iFRAME_ID,
    input  logic                iABORT,
    input  logic [PIX_W-1:0]    iPIX_DATA,
    input  logic                iPIX_VALID,
    output logic                oPIX_READY,
    output logic                oWR_EN,
    output logic [ADDR_W-1:0]   oWR_ADDR,
    output logic [DATA_W-1:0]   oWR_DATA,
    input  logic                iWAIT_REQUEST,
    output logic                oBUSY,
    output logic                oDONE
);

    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS_PER_LINE - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES - 1);

    state_t              r_state;
    state_t              w_next;
    logic [FRAME_W-1:0]  r_frame;
    logic [LINE_W-1:0]   r_line;
    logic [WORD_W-1:0]   r_word;
    logic [DATA_W-1:0]   r_data;
    logic                r_pix_ready;
    logic                r_wr_en;

    logic                w_accept;
    logic                w_take_u;
    logic                w_take_l;
    logic                w_start;
    logic                w_last_word;
    logic                w_last_line;

    assign w_accept    = (r_state == ST_WRITE) && !iWAIT_REQUEST;
    assign w_take_u    = (r_state == ST_PACK_U) && iPIX_VALID
                         && r_pix_ready && !iABORT;
    assign w_take_l    = (r_state == ST_PACK_L) && iPIX_VALID
                         && r_pix_ready && !iABORT;
    assign w_start     = (r_state == ST_IDLE) && iSTART && !iABORT;
    assign w_last_word = (r_word == WORD_LAST);
    assign w_last_line = (r_line == LINE_LAST);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) w_next = ST_PACK_U;
            end
            ST_PACK_U: begin
                if (iABORT)        w_next = ST_IDLE;
                else if (w_take_u) w_next = ST_PACK_L;
            end
            ST_PACK_L: begin
                if (iABORT)        w_next = ST_IDLE;
                else if (w_take_l) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                // An issued write is never withdrawn, even on abort.
                if (w_accept) begin
                    if (iABORT)
                        w_next = ST_IDLE;
                    else if (w_last_word && w_last_line)
                        w_next = ST_DONE;
                    else
                        w_next = ST_PACK_U;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state     <= ST_IDLE;
            r_pix_ready <= 1'b0;
            r_wr_en     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_pix_ready <= (w_next == ST_PACK_U) || (w_next == ST_PACK_L);
            r_wr_en     <= (w_next == ST_WRITE);
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_frame <= '0;
            r_line  <= '0;
            r_word  <= '0;
        end else if (w_start) begin
            r_frame <= iFRAME_ID;
            r_line  <= '0;
            r_word  <= '0;
        end else if (w_accept && !iABORT) begin
            if (!w_last_word) begin
                r_word <= r_word + 1'b1;
            end else if (!w_last_line) begin
                r_word <= '0;
                r_line <= r_line + 1'b1;
            end
        end
    end

    // First byte of a pair lands in the upper half of the word.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_data <= '0;
        end else if (w_take_u) begin
            r_data[15:8] <= iPIX_DATA;
        end else if (w_take_l) begin
            r_data[7:0] <= iPIX_DATA;
        end
    end

    assign oPIX_READY = r_pix_ready;
    assign oWR_EN     = r_wr_en;
    assign oWR_ADDR   = mk_addr(r_frame, r_line, r_word);
    assign oWR_DATA   = r_data;
    assign oBUSY      = (r_state != ST_IDLE);
    assign oDONE      = (r_state == ST_DONE);

endmodule
